// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file access controller.
// The writeback entry layout is used by both the controller and its FIFO.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;
  localparam int WB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } rf_state_t;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: circular buffer of pending register-file writes.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_data,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Serializes operand reads and buffered writebacks onto the single register-file port.
// Reads wait for the writeback FIFO to drain, so no forwarding path is needed.
module regfile_access_ctrl #(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int AW       = rf_pkg::AW,
  parameter int WB_DEPTH = rf_pkg::WB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req_valid,
  output logic            rd_req_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_rw,
  output logic [AW-1:0]   rf_rd,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [XLEN-1:0] rf_din,
  input  logic [XLEN-1:0] rf_outA,
  input  logic [XLEN-1:0] rf_outB
);

  rf_pkg::rf_state_t state_q;
  rf_pkg::rf_state_t state_d;
  rf_pkg::wb_entry_t push_entry;
  rf_pkg::wb_entry_t head;

  logic                      rd_accept;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [$clog2(WB_DEPTH):0] fifo_count;

  // The wb_valid term keeps a read from overtaking a writeback arriving this cycle.
  assign rd_req_ready = rst && (state_q == rf_pkg::IDLE) && (fifo_count == '0) && !wb_valid;
  assign wb_ready     = rst && !full;
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign push         = wb_valid && wb_ready && (wb_rd != '0);
  assign push_entry   = '{rd: wb_rd, data: wb_data};

  // NOTE: state_d gets a default first so no path through the case leaves it unassigned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      rf_pkg::IDLE:    if (rd_accept) state_d = rf_pkg::ISSUE;
      rf_pkg::ISSUE:   state_d = rf_pkg::CAPTURE;
      rf_pkg::CAPTURE: state_d = rf_pkg::RESP;
      rf_pkg::RESP:    if (op_valid && op_ready) state_d = rf_pkg::IDLE;
      default:         state_d = rf_pkg::IDLE;
    endcase
  end

  // Any edge that does not issue a read is free to retire one writeback.
  assign pop = !empty && (state_d != rf_pkg::ISSUE);

  wb_fifo #(
    .DEPTH(WB_DEPTH)
  ) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= rf_pkg::IDLE;
      rf_rw    <= 1'b0;
      rf_rd    <= '0;
      rf_rs1   <= '0;
      rf_rs2   <= '0;
      rf_din   <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      state_q <= state_d;
      rf_rw   <= pop;
      if (pop) begin
        rf_rd  <= head.rd;
        rf_din <= head.data;
      end
      if (rd_accept) begin
        rf_rs1 <= rs1_addr;
        rf_rs2 <= rs2_addr;
      end
      if (state_q == rf_pkg::CAPTURE) begin
        op_valid <= 1'b1;
        op_a     <= (rf_rs1 == '0) ? '0 : rf_outA;
        op_b     <= (rf_rs2 == '0) ? '0 : rf_outB;
      end else if ((state_q == rf_pkg::RESP) && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator-side controller that drives the 32x32 register file's shared read/write port: `rw`, `rd`, `rs1`, `rs2`, `din`, `outA`, `outB`.
- Accepts operand-read requests from decode and writebacks from the execute/memory stages.
- Serializes both onto the single port: one access per cycle, registered read data.
- Returns operand pairs upstream over valid/ready, buffering writebacks in a small FIFO so writeback sources rarely stall.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- WB_DEPTH, 4, writeback FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  operand read request valid
- rd_req_ready  out  1  controller can accept read request
- rs1_addr  in  AW  source register 1
- rs2_addr  in  AW  source register 2
- op_valid  out  1  operand pair valid
- op_ready  in  1  consumer accepts operands
- op_a  out  XLEN  value of rs1
- op_b  out  XLEN  value of rs2
- wb_valid  in  1  writeback valid
- wb_ready  out  1  writeback accepted
- wb_rd  in  AW  destination register
- wb_data  in  XLEN  writeback data
- rf_rw  out  1  1 = write, 0 = read (to register file)
- rf_rd  out  AW  register file write address
- rf_rs1  out  AW  register file read address A
- rf_rs2  out  AW  register file read address B
- rf_din  out  XLEN  register file write data
- rf_outA  in  XLEN  register file read data A (registered, updated only on read cycles)
- rf_outB  in  XLEN  register file read data B

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE and the FIFO empties.
  - rf_rw, rf_rd, rf_rs1, rf_rs2, rf_din, op_a, op_b and op_valid all go to 0.
  - rd_req_ready and wb_ready are forced 0 while rst is low.
- All rf_* outputs and all op_* outputs are registered.
- State machine:
  - IDLE -> ISSUE on read accept.
  - ISSUE -> CAPTURE unconditionally.
  - CAPTURE -> RESP unconditionally.
  - RESP -> IDLE on op_valid && op_ready.
- rd_req_ready = (state == IDLE) && (fifo_count == 0) && !wb_valid. The combinational path from wb_valid is intentional: all prior writebacks reach the register file before any read is issued, so no forwarding logic is required.
- Read accept at edge E0:
  - Set rf_rw = 0, rf_rs1 = rs1_addr, rf_rs2 = rs2_addr.
  - Register file samples at E1; rf_outA/B are valid during the CAPTURE cycle.
  - CAPTURE latches op_a/op_b at E2; op_valid = 1 from E2.
  - Fixed latency: accept edge to op_valid = 2 edges (op_valid visible the 3rd cycle after the request cycle).
- Register 0 reads: op_a/op_b are forced to 0 whenever the corresponding address is 0, regardless of register file contents.
- rf_rs1/rf_rs2 hold their value until the next read accept. Repeat reads while rf_rw = 0 are harmless.
- op_valid, op_a and op_b hold stable until op_ready. op_ready while op_valid = 0 is ignored.
- Writeback FIFO:
  - wb_ready = (fifo_count < WB_DEPTH) && rst.
  - On accept, push {wb_rd, wb_data}.
  - Writes with wb_rd == 0 are accepted but discarded (not pushed).
- Drain:
  - At each edge where the FIFO is non-empty and the next state is not ISSUE, drive rf_rw = 1, rf_rd = head.rd, rf_din = head.data, and pop.
  - Otherwise rf_rw = 0.
  - Drains are allowed during IDLE, CAPTURE and RESP, since register file outputs do not change on write cycles.
- Simultaneous push and pop: count unchanged, both take effect. A push into a full FIFO cannot occur because wb_ready = 0.
- FIFO pointers wrap modulo WB_DEPTH. Order is strictly FIFO, so the last write to a given register wins.
- Read ordering: a read observes every writeback accepted before the read accept cycle and none accepted after it.
- Reset mid-operation: any in-flight read is dropped (op_valid returns to 0) and FIFO contents are lost. The register file's own contents are not this block's concern.

Decomposition:
- Shared package `rf_pkg`: XLEN, AW, NUM_REGS = 32, the `rf_state_t` enum (IDLE, ISSUE, CAPTURE, RESP), and the `wb_entry_t` struct {rd, data}.
- One natural sub-module, `wb_fifo`: a synchronous FIFO with parameter DEPTH, push/pop, full/empty/count, async active-low reset.
- The main FSM and port muxing stay in `regfile_access_ctrl`.

Test Plan:
- Reset then idle: after rst is released, all outputs are 0, rd_req_ready = 1 and wb_ready = 1. rf_rw stays 0 for 10 cycles with no requests.
- Single write then read:
  - Stimulus: wb x5 = 0xDEADBEEF; the register file model sees rf_rw = 1, rf_rd = 5 on the next edge. Then read rs1 = 5, rs2 = 0.
  - Response: op_valid rises exactly 2 edges after accept, op_a = 0xDEADBEEF, op_b = 0.
- Read gating:
  - Stimulus: wb_valid and rd_req_valid both high in IDLE.
  - Response: rd_req_ready = 0 that cycle; the write drains first; the read then sees the new value.
- FIFO full:
  - Stimulus: hold the FSM in RESP (op_ready = 0) while pushing 5 writes to x1..x5.
  - Response: the first 4 accepted back-to-back because drains occur in RESP; wb_ready never drops the 5th accept; written order on rf_rd is 1, 2, 3, 4, 5.
- Backpressure: hold op_ready = 0 for 7 cycles after op_valid. op_a/op_b remain stable, rd_req_ready = 0 throughout, and there is exactly one handshake.
- x0 write and mid-read reset:
  - Stimulus: wb x0 = 0x1234.
  - Response: accepted with no rf_rw = 1 pulse.
  - Stimulus: pulse rst low during CAPTURE.
  - Response: op_valid = 0 immediately; the FSM restarts in IDLE.
